// File: rtl/macroblock_block_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the 4:2:0 macroblock block sequencer.
package macroblock_block_sequencer_pkg;

  localparam int unsigned NUM_BLOCKS_420  = 6;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned PAT_W           = 6;
  localparam int unsigned CBP_TIMEOUT_DEF = 16;

  localparam logic [PAT_W-1:0] CBP_INTRA_ALL = 6'h3F;
  localparam logic [PAT_W-1:0] CBP_NONE      = 6'h00;

  // Blocks in decode order: Y0..Y3 are 0..3, Cb is 4, Cr is the last block.
  localparam logic [IDX_W-1:0] BLK_Y0 = 3'd0;
  localparam logic [IDX_W-1:0] BLK_CR = IDX_W'(NUM_BLOCKS_420 - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CBP_REQ  = 3'd1,
    ST_CBP_WAIT = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT_BLK = 3'd4,
    ST_DONE     = 3'd5
  } mbs_state_e;

  // Pattern bit 5 is Y0 and bit 0 is Cr, so block idx maps to bit (5 - idx).
  function automatic logic block_coded(input logic [PAT_W-1:0] pat,
                                       input logic [IDX_W-1:0] idx);
    return pat[BLK_CR - idx];
  endfunction

endpackage

// File: rtl/macroblock_block_sequencer.sv
// Per-macroblock block sequencer: obtains the coded block pattern (forced, zero or from the
// CBP VLC decoder) and then issues the six 4:2:0 block decodes in order.
module macroblock_block_sequencer
  import macroblock_block_sequencer_pkg::*;
#(
  parameter int unsigned CBP_TIMEOUT = CBP_TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Mb_Start_I,
  input  logic             Mb_Intra_I,
  input  logic             Mb_Pattern_I,
  output logic             Cbp_Start_O,
  input  logic             Cbp_Valid_I,
  input  logic [PAT_W-1:0] Cbp_Symbol_I,
  output logic             Block_Start_O,
  output logic [IDX_W-1:0] Block_Index_O,
  output logic             Block_Coded_O,
  input  logic             Block_Done_I,
  output logic [PAT_W-1:0] Pattern_O,
  output logic             Busy_O,
  output logic             Mb_Done_O,
  output logic             Error_O
);

  localparam int unsigned TMO_W = $clog2(CBP_TIMEOUT + 1);

  mbs_state_e       state_q;
  logic [TMO_W-1:0] tmo_q;
  logic [IDX_W-1:0] idx_q;
  logic [PAT_W-1:0] pattern_q;
  logic             cbp_start_q;
  logic             block_start_q;
  logic             block_coded_q;
  logic             busy_q;
  logic             mb_done_q;
  logic             error_q;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmo_q         <= '0;
      idx_q         <= BLK_Y0;
      pattern_q     <= CBP_NONE;
      cbp_start_q   <= 1'b0;
      block_start_q <= 1'b0;
      block_coded_q <= 1'b0;
      busy_q        <= 1'b0;
      mb_done_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      cbp_start_q   <= 1'b0;
      block_start_q <= 1'b0;
      mb_done_q     <= 1'b0;

      // A new macroblock while one is in flight is dropped and flagged.
      if (Mb_Start_I && (state_q != ST_IDLE)) begin
        error_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (Mb_Start_I) begin
            busy_q <= 1'b1;
            idx_q  <= BLK_Y0;
            if (Mb_Intra_I) begin
              pattern_q     <= CBP_INTRA_ALL;
              block_coded_q <= block_coded(CBP_INTRA_ALL, BLK_Y0);
              state_q       <= ST_ISSUE;
            end else if (!Mb_Pattern_I) begin
              pattern_q     <= CBP_NONE;
              block_coded_q <= block_coded(CBP_NONE, BLK_Y0);
              state_q       <= ST_ISSUE;
            end else begin
              cbp_start_q <= 1'b1;
              state_q     <= ST_CBP_REQ;
            end
          end
        end

        // Decoder valid is stale while its start pulse is out.
        ST_CBP_REQ: begin
          tmo_q   <= '0;
          state_q <= ST_CBP_WAIT;
        end

        ST_CBP_WAIT: begin
          if (Cbp_Valid_I) begin
            pattern_q     <= Cbp_Symbol_I;
            block_coded_q <= block_coded(Cbp_Symbol_I, BLK_Y0);
            state_q       <= ST_ISSUE;
          end else if (tmo_q >= TMO_W'(CBP_TIMEOUT - 1)) begin
            // Give up on the decoder; finish the macroblock as all-uncoded for concealment.
            error_q       <= 1'b1;
            pattern_q     <= CBP_NONE;
            block_coded_q <= block_coded(CBP_NONE, BLK_Y0);
            state_q       <= ST_ISSUE;
          end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        ST_ISSUE: begin
          block_start_q <= 1'b1;
          state_q       <= ST_WAIT_BLK;
        end

        ST_WAIT_BLK: begin
          if (Block_Done_I) begin
            if (idx_q == BLK_CR) begin
              mb_done_q <= 1'b1;
              state_q   <= ST_DONE;
            end else begin
              idx_q         <= idx_q + IDX_W'(1);
              block_coded_q <= block_coded(pattern_q, idx_q + IDX_W'(1));
              state_q       <= ST_ISSUE;
            end
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          idx_q   <= BLK_Y0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Cbp_Start_O   = cbp_start_q;
  assign Block_Start_O = block_start_q;
  assign Block_Index_O = idx_q;
  assign Block_Coded_O = block_coded_q;
  assign Pattern_O     = pattern_q;
  assign Busy_O        = busy_q;
  assign Mb_Done_O     = mb_done_q;
  assign Error_O       = error_q;

  // Invariants: index bounded, single-cycle pulses tied to their states.
  a_idx_range: assert property (@(posedge clock) disable iff (reset)
    idx_q <= BLK_CR);
  a_blk_state: assert property (@(posedge clock) disable iff (reset)
    block_start_q |-> (state_q == ST_WAIT_BLK));
  a_blk_pulse: assert property (@(posedge clock) disable iff (reset)
    block_start_q |=> !block_start_q);
  a_cbp_state: assert property (@(posedge clock) disable iff (reset)
    cbp_start_q |-> (state_q == ST_CBP_REQ));
  a_done_state: assert property (@(posedge clock) disable iff (reset)
    mb_done_q |-> (state_q == ST_DONE));

endmodule

// File: tb/tb_macroblock_block_sequencer.sv
// Directed, table-driven bench for macroblock_block_sequencer with hand-computed expectations.
module tb_macroblock_block_sequencer;

  logic       clock;
  logic       reset;
  logic       Mb_Start_I;
  logic       Mb_Intra_I;
  logic       Mb_Pattern_I;
  logic       Cbp_Start_O;
  logic       Cbp_Valid_I;
  logic [5:0] Cbp_Symbol_I;
  logic       Block_Start_O;
  logic [2:0] Block_Index_O;
  logic       Block_Coded_O;
  logic       Block_Done_I;
  logic [5:0] Pattern_O;
  logic       Busy_O;
  logic       Mb_Done_O;
  logic       Error_O;

  macroblock_block_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .Mb_Start_I    (Mb_Start_I),
    .Mb_Intra_I    (Mb_Intra_I),
    .Mb_Pattern_I  (Mb_Pattern_I),
    .Cbp_Start_O   (Cbp_Start_O),
    .Cbp_Valid_I   (Cbp_Valid_I),
    .Cbp_Symbol_I  (Cbp_Symbol_I),
    .Block_Start_O (Block_Start_O),
    .Block_Index_O (Block_Index_O),
    .Block_Coded_O (Block_Coded_O),
    .Block_Done_I  (Block_Done_I),
    .Pattern_O     (Pattern_O),
    .Busy_O        (Busy_O),
    .Mb_Done_O     (Mb_Done_O),
    .Error_O       (Error_O)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string      name;
    bit         intra;
    bit         pat;
    int         cbp_delay;
    logic [5:0] sym;
    bit         timeout;
    int         done_delay;
    int         inj_idx;
    logic [5:0] exp_pattern;
    logic [5:0] exp_coded;
    int         exp_cbp_starts;
    int         exp_latency;
    bit         exp_error;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({Cbp_Start_O, Block_Start_O, Block_Index_O, Block_Coded_O,
                Pattern_O, Busy_O, Mb_Done_O, Error_O});
  endfunction

  function automatic vec_t mk(input string name, input bit intra, input bit pat,
                              input int cbp_delay, input logic [5:0] sym, input bit timeout,
                              input int done_delay, input int inj_idx,
                              input logic [5:0] exp_pattern, input logic [5:0] exp_coded,
                              input int exp_cbp_starts, input int exp_latency,
                              input bit exp_error);
    vec_t v;
    v.name = name; v.intra = intra; v.pat = pat; v.cbp_delay = cbp_delay; v.sym = sym;
    v.timeout = timeout; v.done_delay = done_delay; v.inj_idx = inj_idx;
    v.exp_pattern = exp_pattern; v.exp_coded = exp_coded;
    v.exp_cbp_starts = exp_cbp_starts; v.exp_latency = exp_latency; v.exp_error = exp_error;
    return v;
  endfunction

  // Drives one macroblock, acting as both CBP decoder and block stage, and checks the result.
  task automatic run_mb(input vec_t v, input bit pre_reset);
    int         blocks     = 0;
    int         cbp_starts = 0;
    int         wait_cnt   = 0;
    int         done_wait  = 0;
    int         first_blk  = -1;
    int         err_wait   = -1;
    bit         cbp_active = 1'b0;
    bit         pending    = 1'b0;
    bit         finished   = 1'b0;
    bit         hold_ok    = 1'b1;
    bit         idx_ok     = 1'b1;
    bit         quiet_ok   = 1'b1;
    bit         busy_at_done = 1'b0;
    logic [2:0] cur_idx    = '0;
    logic       cur_coded  = 1'b0;
    logic [5:0] coded_seq  = '0;

    if (pre_reset) do_reset();
    Cbp_Symbol_I = v.sym;
    Mb_Intra_I   = v.intra;
    Mb_Pattern_I = v.pat;
    Mb_Start_I   = 1'b1;
    step();
    Mb_Start_I   = 1'b0;
    Mb_Intra_I   = 1'b0;
    Mb_Pattern_I = 1'b0;
    chk({v.name, "/busy_rise"}, 32'(Busy_O), 32'd1);

    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      Mb_Start_I   = 1'b0;
      Mb_Intra_I   = 1'b0;
      Block_Done_I = 1'b0;
      Cbp_Valid_I  = 1'b0;
      if (Cbp_Start_O) begin
        cbp_starts++;
        cbp_active = 1'b1;
        wait_cnt   = 0;
      end else if (cbp_active) begin
        wait_cnt++;
        if (!v.timeout && wait_cnt == v.cbp_delay) begin
          Cbp_Valid_I = 1'b1;
          cbp_active  = 1'b0;
        end
      end
      if (v.timeout && err_wait < 0 && Error_O) err_wait = wait_cnt;
      if (pending && (Block_Index_O !== cur_idx || Block_Coded_O !== cur_coded)) hold_ok = 1'b0;
      if (Block_Start_O) begin
        if (blocks == 0) first_blk = cyc + 1;
        if (Block_Index_O !== 3'(blocks)) idx_ok = 1'b0;
        cur_idx   = Block_Index_O;
        cur_coded = Block_Coded_O;
        if (blocks < 6) coded_seq[5-blocks] = Block_Coded_O;
        blocks++;
        pending   = 1'b1;
        done_wait = 0;
        if (v.inj_idx >= 0 && Block_Index_O == 3'(v.inj_idx)) begin
          Mb_Start_I   = 1'b1;
          Mb_Intra_I   = 1'b1;
          Mb_Pattern_I = 1'b0;
        end
      end
      if (pending) begin
        if (done_wait == v.done_delay) begin
          Block_Done_I = 1'b1;
          pending      = 1'b0;
        end else begin
          done_wait++;
        end
      end
      if (Mb_Done_O) begin
        busy_at_done = Busy_O;
        finished     = 1'b1;
      end else begin
        step();
      end
    end

    chk({v.name, "/mb_done_seen"}, 32'(finished), 32'd1);
    chk({v.name, "/block_count"}, 32'(blocks), 32'd6);
    chk({v.name, "/index_order"}, 32'(idx_ok), 32'd1);
    chk({v.name, "/index_coded_hold"}, 32'(hold_ok), 32'd1);
    chk({v.name, "/coded_seq"}, 32'(coded_seq), 32'(v.exp_coded));
    chk({v.name, "/cbp_starts"}, 32'(cbp_starts), 32'(v.exp_cbp_starts));
    chk({v.name, "/first_block_latency"}, 32'(first_blk), 32'(v.exp_latency));
    chk({v.name, "/busy_at_done"}, 32'(busy_at_done), 32'd1);
    chk({v.name, "/pattern"}, 32'(Pattern_O), 32'(v.exp_pattern));
    chk({v.name, "/error"}, 32'(Error_O), 32'(v.exp_error));
    if (v.timeout) chk({v.name, "/error_rise_cycle"}, 32'(err_wait), 32'd17);

    Block_Done_I = 1'b0;
    Cbp_Valid_I  = 1'b0;
    Mb_Start_I   = 1'b0;
    step();
    chk({v.name, "/busy_fall"}, 32'({Busy_O, Mb_Done_O}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (Block_Start_O || Cbp_Start_O || Mb_Done_O || Busy_O) quiet_ok = 1'b0;
    end
    chk({v.name, "/quiet_after"}, 32'(quiet_ok), 32'd1);
  endtask

  // Reset lands while block 3 is outstanding, with its done pulse pending.
  task automatic reset_mid();
    bit found    = 1'b0;
    bit quiet_ok = 1'b1;
    do_reset();
    Mb_Intra_I = 1'b1;
    Mb_Start_I = 1'b1;
    step();
    Mb_Start_I = 1'b0;
    Mb_Intra_I = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      Block_Done_I = 1'b0;
      if (Block_Start_O && Block_Index_O == 3'd3) begin
        found = 1'b1;
      end else begin
        if (Block_Start_O) Block_Done_I = 1'b1;
        step();
      end
    end
    chk("rst_mid/reached_idx3", 32'(found), 32'd1);
    reset        = 1'b1;
    Block_Done_I = 1'b1;
    step();
    chk("rst_mid/outputs_zero", all_outs(), 32'd0);
    reset = 1'b0;
    step();
    Block_Done_I = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (Block_Start_O || Mb_Done_O || Busy_O || Cbp_Start_O || Block_Index_O != 3'd0)
        quiet_ok = 1'b0;
      step();
    end
    chk("rst_mid/no_pulses_after", 32'(quiet_ok), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    reset        = 1'b1;
    Mb_Start_I   = 1'b0;
    Mb_Intra_I   = 1'b0;
    Mb_Pattern_I = 1'b0;
    Cbp_Valid_I  = 1'b0;
    Cbp_Symbol_I = 6'h00;
    Block_Done_I = 1'b0;

    //            name          intra pat dly sym    tmo dd inj  pattern coded  cbp lat err
    vecs[0] = mk("intra",        1, 0,  0, 6'h00, 0, 0, -1, 6'h3F, 6'h3F, 0,  2, 0);
    vecs[1] = mk("no_pattern",   0, 0,  0, 6'h00, 0, 2, -1, 6'h00, 6'h00, 0,  2, 0);
    vecs[2] = mk("cbp_25",       0, 1,  5, 6'h25, 0, 1, -1, 6'h25, 6'h25, 1,  8, 0);
    vecs[3] = mk("cbp_zero",     0, 1,  1, 6'h00, 0, 0, -1, 6'h00, 6'h00, 1,  4, 0);
    vecs[4] = mk("cbp_timeout",  0, 1,  0, 6'h2A, 1, 0, -1, 6'h00, 6'h00, 1, 19, 1);
    vecs[5] = mk("start_busy",   0, 1,  2, 6'h1C, 0, 3,  2, 6'h1C, 6'h1C, 1,  5, 1);
    vecs[6] = mk("intra_prio",   1, 1,  0, 6'h01, 0, 1, -1, 6'h3F, 6'h3F, 0,  2, 0);

    do_reset();
    chk("reset/outputs_zero", all_outs(), 32'd0);

    for (int i = 0; i < 7; i++) run_mb(vecs[i], 1'b1);

    reset_mid();
    vecs[0].name = "intra_after_reset";
    run_mb(vecs[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
